sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 SHALL have parameter REFRESH_GAP, default 7: maximum consecutive granted slots before one idle (refresh) slot is forced.
REQ-002 SHALL have ports: clk, input, 1, 112 MHz memory clock (same clock as the SDRAM controller).
REQ-003 SHALL have ports: reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports: clkref, input, 1, 14 MHz reference, synchronous to clk (same signal fed to the controller).
REQ-005 SHALL have ports: cpu_req input 1 (level, held until cpu_ack); cpu_we input 1; cpu_addr input 25; cpu_din input 8; cpu_dout output 8; cpu_ack output 1 (one-clk pulse).
REQ-006 SHALL have ports: dl_wr input 1 (one-clk write strobe from the ROM/tape download path); dl_addr input 25; dl_data input 8; dl_busy output 1; dl_err output 1 (sticky).
REQ-007 SHALL have ports to the controller: mem_addr output 25; mem_din output 8; mem_oe output 1; mem_we output 1; mem_dout input 8.
REQ-008 Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named reset.

Function
REQ-009 Phase counter ph (3 bit): clkref_d <= clkref each clk; if clkref=1 and clkref_d=0, ph <= 6; else ph <= ph+1 (wraps 7->0).
REQ-010 Slot boundary is the clk edge where ph==7; all grant decisions and mem_* output updates occur only at that edge, so mem_* are stable for all 8 clks of the slot (ph 0..7).
REQ-011 Download latch: dl_wr=1 with dl_busy=0 captures dl_addr/dl_data and sets dl_busy the next clk.
REQ-012 dl_wr=1 while dl_busy=1: strobe dropped, latched data unchanged, dl_err set and held until reset.
REQ-013 Grant priority at slot boundary: forced-idle > download > CPU > idle.
REQ-014 Download grant: mem_addr=latched dl_addr, mem_din=latched dl_data, mem_we=1, mem_oe=0; dl_busy cleared at the same edge.
REQ-015 dl_wr arriving on the slot-boundary edge itself is latched only; it is granted no earlier than the next boundary.
REQ-016 CPU grant (cpu_req=1 sampled at boundary, CPU not already in service): mem_addr=cpu_addr, mem_din=cpu_din, mem_we=cpu_we, mem_oe=~cpu_we.
REQ-017 Idle/forced-idle slot: mem_oe=0, mem_we=0, mem_addr and mem_din hold previous values (controller performs auto-refresh).
REQ-018 Completion: at the clk edge where ph==6 inside a CPU slot, cpu_ack pulses high for exactly one clk; for reads cpu_dout <= mem_dout at that edge.
REQ-019 cpu_dout holds its value at all other times, including across writes and download slots.
REQ-020 A CPU request that remains high after cpu_ack is treated as a new request at the next boundary (no duplicate ack within one slot).
REQ-021 cpu_req deasserted before its grant: no access, no ack.
REQ-022 Refresh guarantee: counter busy_cnt increments on each granted slot, clears on each idle slot; when busy_cnt==REFRESH_GAP at a boundary, that slot is forced idle regardless of pending requests, and busy_cnt clears.
REQ-023 Latency: CPU request present at a boundary with no download pending completes (cpu_ack) 7 clks after that boundary edge; worst case adds one download slot plus one forced-idle slot.
REQ-024 Until the first clkref rising edge after reset, ph free-runs from 0; grants follow ph as defined (no special lock state).

Reset
REQ-025 While reset=1: ph=0, clkref_d=0, busy_cnt=0, mem_oe=0, mem_we=0, mem_addr=0, mem_din=0, cpu_dout=0, cpu_ack=0, dl_busy=0, dl_err=0, download latch cleared.
REQ-026 Reset asserted mid-slot immediately (asynchronously) drops mem_oe/mem_we; any pending request is discarded and never acknowledged.

Verification
REQ-027 CPU read: clkref periodic, cpu_req=1, cpu_we=0, cpu_addr=0x0012345, mem_dout=0xA5 -> mem_oe=1 for exactly 8 clks, cpu_ack one pulse at ph==6, cpu_dout=0xA5.
REQ-028 Contention: dl_wr(addr 0x0000100, data 0x3C) and cpu_req write in the same pre-boundary window -> first slot mem_we=1, mem_addr=0x0000100, mem_din=0x3C; CPU write granted in the following slot, one cpu_ack.
REQ-029 Overrun: two dl_wr strobes 2 clks apart before a boundary -> first data written, second dropped, dl_err=1 and stays 1 until reset.
REQ-030 Starvation: cpu_req held high continuously for 20 slots -> after every 7 granted slots exactly one slot with mem_oe=mem_we=0.
REQ-031 Alignment: start clkref at arbitrary phase -> after first clkref rising edge, ph==7 boundaries recur every 8 clks at fixed offset 2 clks after the detected edge.
REQ-032 Reset mid-read at ph==3 -> mem_oe=0 immediately, no cpu_ack, cpu_dout=0; normal grants resume after release.

Source files
------------

// File: rtl/sdram_arb.sv
// Purpose : slot arbiter sharing one SDRAM controller between the CPU and the
//           ROM/tape download path, with a guaranteed auto-refresh slot.
// Latency : a CPU request seen at a slot boundary is acked 7 clks after that
//           edge; worst case adds one download slot and one forced-idle slot.
// Backpressure: the CPU holds cpu_req until cpu_ack. The download path has a
//           one-deep latch; a strobe while it is full is dropped and flagged
//           on the sticky dl_err.
//
// Ports:
//   clk, reset   112 MHz memory clock, asynchronous active-high reset
//   clkref       14 MHz reference (synchronous to clk), aligns the 8-clk slot
//   cpu_*        level request / one-clk ack CPU port, 25-bit addr, 8-bit data
//   dl_*         one-clk write strobe download port, busy and sticky error
//   mem_*        command/data to the SDRAM controller, stable for a whole slot
module sdram_arb #(
    parameter int REFRESH_GAP = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkref,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,

    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_busy,
    output logic        dl_err,

    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic [7:0]  mem_dout
);

    // Wide enough to hold REFRESH_GAP itself (the counter never exceeds it).
    localparam int            CW  = $clog2(REFRESH_GAP + 2);
    localparam logic [CW-1:0] GAP = CW'(REFRESH_GAP);

    // What the current slot is doing. The *_DONE states keep the command on
    // the bus for the rest of the slot after the CPU has been acknowledged,
    // so a phase realignment that revisits ph==6 cannot ack twice.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DL      = 3'd1,
        S_RD      = 3'd2,
        S_RD_DONE = 3'd3,
        S_WR      = 3'd4,
        S_WR_DONE = 3'd5
    } slot_t;

    slot_t          state_q;
    slot_t          state_d;

    logic [2:0]     ph;
    logic           clkref_d;
    logic [CW-1:0]  busy_cnt;
    logic [24:0]    dl_addr_q;
    logic [7:0]     dl_data_q;

    logic           boundary;
    logic           force_idle;
    logic           grant_dl;
    logic           grant_cpu;
    logic           ack_now;

    // Slot boundary is the edge at which ph==7; every arbitration decision
    // and every mem_addr/mem_din update is confined to that edge.
    assign boundary   = (ph == 3'd7);
    assign force_idle = (busy_cnt == GAP);
    assign grant_dl   = boundary && !force_idle && dl_busy;
    assign grant_cpu  = boundary && !force_idle && !dl_busy && cpu_req;
    assign ack_now    = (ph == 3'd6) && ((state_q == S_RD) || (state_q == S_WR));

    // ------------------------------------------------------------------
    // Slot FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (boundary) begin
            // forced-idle > download > CPU > idle
            if (force_idle) begin
                state_d = S_IDLE;
            end else if (dl_busy) begin
                state_d = S_DL;
            end else if (cpu_req) begin
                state_d = cpu_we ? S_WR : S_RD;
            end else begin
                state_d = S_IDLE;
            end
        end else if (ph == 3'd6) begin
            if (state_q == S_RD) begin
                state_d = S_RD_DONE;
            end else if (state_q == S_WR) begin
                state_d = S_WR_DONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM: outputs. Decoded straight from the state register so that
    // reset drops the command strobes immediately, mid-slot.
    // ------------------------------------------------------------------
    always_comb begin
        mem_oe = 1'b0;
        mem_we = 1'b0;
        case (state_q)
            S_RD, S_RD_DONE:       mem_oe = 1'b1;
            S_WR, S_WR_DONE, S_DL: mem_we = 1'b1;
            default: begin
                mem_oe = 1'b0;
                mem_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase tracking. A clkref rising edge forces ph to 6, which places
    // the boundary (ph==7 edge) two clks after the detected edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkref_d <= 1'b0;
            ph       <= 3'd0;
        end else begin
            clkref_d <= clkref;
            if (clkref && !clkref_d) begin
                ph <= 3'd6;
            end else begin
                ph <= ph + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Download latch. A strobe on a boundary edge is only latched here; the
    // grant logic looks at dl_busy from before the edge, so it waits for the
    // next boundary. A strobe while full is dropped and recorded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_busy   <= 1'b0;
            dl_err    <= 1'b0;
            dl_addr_q <= '0;
            dl_data_q <= '0;
        end else begin
            if (dl_wr && !dl_busy) begin
                dl_busy   <= 1'b1;
                dl_addr_q <= dl_addr;
                dl_data_q <= dl_data;
            end else if (grant_dl) begin
                dl_busy   <= 1'b0;
            end
            if (dl_wr && dl_busy) begin
                dl_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Refresh guarantee: count back-to-back granted slots, force one idle
    // slot once REFRESH_GAP of them have run.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (boundary) begin
            if (grant_dl || grant_cpu) begin
                busy_cnt <= busy_cnt + CW'(1);
            end else begin
                busy_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address/data to the controller: loaded only on a granted boundary,
    // held through idle slots so the controller sees a quiet bus.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (grant_dl) begin
            mem_addr <= dl_addr_q;
            mem_din  <= dl_data_q;
        end else if (grant_cpu) begin
            mem_addr <= cpu_addr;
            mem_din  <= cpu_din;
        end
    end

    // ------------------------------------------------------------------
    // CPU completion: one-clk ack at the ph==6 edge of a CPU slot; read data
    // is captured at the same edge and held otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ack  <= 1'b0;
            cpu_dout <= '0;
        end else begin
            cpu_ack <= ack_now;
            if (ack_now && (state_q == S_RD)) begin
                cpu_dout <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
`timescale 1ns/1ps
module tb_sdram_arb;

    localparam int GAP    = 7;
    localparam int K_IDLE = 0;
    localparam int K_DL   = 1;
    localparam int K_CPU  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clkref = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [24:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_busy;
    logic        dl_err;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_dout = '0;

    sdram_arb #(.REFRESH_GAP(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .clkref   (clkref),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_ack  (cpu_ack),
        .dl_wr    (dl_wr),
        .dl_addr  (dl_addr),
        .dl_data  (dl_data),
        .dl_busy  (dl_busy),
        .dl_err   (dl_err),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- clkref source: 8-clk period, 50% duty ----------------
    logic cr_en  = 1'b0;
    int   cr_off = 0;
    int   ncyc   = 0;
    initial forever begin
        @(negedge clk);
        ncyc   = ncyc + 1;
        clkref = cr_en && (((ncyc + cr_off) % 8) < 4);
    end

    // ---------------- reference model (slot level) ----------------
    int          m_ph = 0;
    logic        m_ref_prev = 1'b0;
    int          m_run = 0;          // granted slots since the last idle slot
    int          m_kind = K_IDLE;
    logic        m_we_slot = 1'b0;
    logic        m_acked = 1'b0;
    logic        m_ack = 1'b0;
    logic [7:0]  m_dout = '0;
    logic [24:0] m_addr = '0;
    logic [7:0]  m_din = '0;
    logic        m_err = 1'b0;
    logic [32:0] dl_q[$];
    logic        was_busy;
    int          pcyc = 0;
    int          det_cyc = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_ph = 0; m_ref_prev = 1'b0; m_run = 0; m_kind = K_IDLE;
            m_we_slot = 1'b0; m_acked = 1'b0; m_ack = 1'b0; m_dout = '0;
            m_addr = '0; m_din = '0; m_err = 1'b0;
            dl_q.delete();
        end else begin
            pcyc++;
            was_busy = (dl_q.size() != 0);
            m_ack = 1'b0;
            if (m_kind == K_CPU && !m_acked && m_ph == 6) begin
                m_ack = 1'b1;
                m_acked = 1'b1;
                if (!m_we_slot) m_dout = mem_dout;
            end
            if (m_ph == 7) begin
                if (m_run == GAP) begin
                    m_kind = K_IDLE; m_run = 0;
                end else if (was_busy) begin
                    {m_addr, m_din} = dl_q.pop_front();
                    m_kind = K_DL; m_run++;
                end else if (cpu_req) begin
                    m_kind = K_CPU; m_we_slot = cpu_we; m_addr = cpu_addr;
                    m_din = cpu_din; m_acked = 1'b0; m_run++;
                end else begin
                    m_kind = K_IDLE; m_run = 0;
                end
            end
            if (dl_wr) begin
                if (was_busy) m_err = 1'b1;
                else dl_q.push_back({dl_addr, dl_data});
            end
            if (clkref && !m_ref_prev) begin
                m_ph = 6;
                det_cyc = pcyc;
            end else begin
                m_ph = (m_ph + 1) % 8;
            end
            m_ref_prev = clkref;
        end
    end

    // ---------------- per-cycle scoreboard ----------------
    initial forever begin
        @(negedge clk);
        check_val("mem_oe",   mem_oe,   (m_kind == K_CPU && !m_we_slot));
        check_val("mem_we",   mem_we,   (m_kind == K_DL || (m_kind == K_CPU && m_we_slot)));
        check_val("mem_addr", mem_addr, m_addr);
        check_val("mem_din",  mem_din,  m_din);
        check_val("cpu_ack",  cpu_ack,  m_ack);
        check_val("cpu_dout", cpu_dout, m_dout);
        check_val("dl_busy",  dl_busy,  (dl_q.size() != 0));
        check_val("dl_err",   dl_err,   m_err);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ph(input int p);
        for (int i = 0; i < 16 && m_ph != p; i++) @(negedge clk);
        check_val("ph_sync", m_ph, p);
    endtask

    task automatic new_cpu_op();
        cpu_we   = 1'($urandom_range(0, 1));
        cpu_addr = 25'($urandom);
        cpu_din  = 8'($urandom);
    endtask

    int          acks, oe_cnt, run, idles, n_al, en_cyc;
    logic        got_dl, got_cpu, seen_idle, seen_500;
    logic [24:0] first_addr;
    logic [7:0]  first_din, cpu_slot_din;

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        check_val("rst_oe",   mem_oe,   0);
        check_val("rst_we",   mem_we,   0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_din",  mem_din,  0);
        check_val("rst_dout", cpu_dout, 0);
        check_val("rst_ack",  cpu_ack,  0);
        check_val("rst_busy", dl_busy,  0);
        check_val("rst_err",  dl_err,   0);
        reset = 1'b0;

        // ph free-runs before any clkref, then clkref starts at a random phase
        repeat (11) @(negedge clk);
        cr_off = $urandom_range(0, 7);
        cr_en  = 1'b1;
        repeat (20) @(negedge clk);

        // ---- single CPU read ----
        mem_dout = 8'hA5; cpu_we = 1'b0; cpu_addr = 25'h0012345; cpu_req = 1'b1;
        oe_cnt = 0; acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_oe) oe_cnt++;
            if (cpu_ack) begin acks++; cpu_req = 1'b0; end
        end
        check_val("rd_oe_clks", oe_cnt, 8);
        check_val("rd_acks", acks, 1);
        check_val("rd_dout", cpu_dout, 8'hA5);

        // ---- download and CPU write contend for the same boundary ----
        wait_ph(3);
        dl_wr = 1'b1; dl_addr = 25'h0000100; dl_data = 8'h3C;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h0000200; cpu_din = 8'h77;
        @(negedge clk);
        dl_wr = 1'b0;
        first_addr = '1; first_din = '1; cpu_slot_din = '0;
        got_dl = 1'b0; got_cpu = 1'b0; acks = 0;
        for (int i = 0; i < 48; i++) begin
            if (mem_we && !got_dl) begin got_dl = 1'b1; first_addr = mem_addr; first_din = mem_din; end
            if (mem_we && mem_addr == 25'h0000200 && !got_cpu) begin got_cpu = 1'b1; cpu_slot_din = mem_din; end
            if (cpu_ack) begin acks++; cpu_req = 1'b0; end
            @(negedge clk);
        end
        check_val("ct_dl_addr", first_addr, 25'h0000100);
        check_val("ct_dl_din", first_din, 8'h3C);
        check_val("ct_cpu_slot", got_cpu, 1);
        check_val("ct_cpu_din", cpu_slot_din, 8'h77);
        check_val("ct_acks", acks, 1);

        // ---- download overrun ----
        wait_ph(1);
        dl_wr = 1'b1; dl_addr = 25'h0000400; dl_data = 8'h11;
        @(negedge clk); dl_wr = 1'b0;
        @(negedge clk); dl_wr = 1'b1; dl_addr = 25'h0000500; dl_data = 8'h22;
        @(negedge clk); dl_wr = 1'b0;
        check_val("ov_err_set", dl_err, 1);
        got_dl = 1'b0; seen_500 = 1'b0; first_addr = '1; first_din = '1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_we && !got_dl) begin got_dl = 1'b1; first_addr = mem_addr; first_din = mem_din; end
            if (mem_addr == 25'h0000500) seen_500 = 1'b1;
        end
        check_val("ov_addr", first_addr, 25'h0000400);
        check_val("ov_din", first_din, 8'h11);
        check_val("ov_dropped", seen_500, 0);
        check_val("ov_err_hold", dl_err, 1);

        // ---- starvation: CPU request never drops ----
        new_cpu_op(); cpu_req = 1'b1;
        run = 0; idles = 0; seen_idle = 1'b0;
        for (int i = 0; i < 24 * 8; i++) begin
            @(negedge clk);
            mem_dout = 8'($urandom);
            if (cpu_ack) new_cpu_op();
            if (m_ph == 0) begin
                if (!mem_oe && !mem_we) begin
                    if (seen_idle) check_val("starve_run", run, GAP);
                    seen_idle = 1'b1; run = 0; idles++;
                end else begin
                    run++;
                end
            end
        end
        cpu_req = 1'b0;
        check_val("starve_idles", idles >= 2, 1);

        // ---- clkref realignment at a new arbitrary phase ----
        repeat (12) @(negedge clk);
        cr_en = 1'b0;
        repeat (12) @(negedge clk);
        cr_off = $urandom_range(0, 7); en_cyc = pcyc; cr_en = 1'b1;
        cpu_we = 1'b0; cpu_addr = 25'($urandom); cpu_req = 1'b1; n_al = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            mem_dout = 8'($urandom);
            if (cpu_ack) begin
                if (det_cyc > en_cyc) begin
                    check_val("align_ack", (pcyc - det_cyc) % 8, 1);
                    n_al++;
                end
                cpu_addr = 25'($urandom);
            end
        end
        cpu_req = 1'b0;
        check_val("align_cnt", n_al >= 4, 1);

        // ---- reset in the middle of a read ----
        repeat (10) @(negedge clk);
        mem_dout = 8'h5A; cpu_we = 1'b0; cpu_addr = 25'h0001234; cpu_req = 1'b1;
        for (int i = 0; i < 40 && !(mem_oe && m_ph == 3); i++) @(negedge clk);
        check_val("rr_oe_pre", mem_oe, 1);
        #1 reset = 1'b1; cpu_req = 1'b0;
        #1;
        check_val("rr_oe", mem_oe, 0);
        check_val("rr_dout", cpu_dout, 0);
        acks = 0;
        repeat (3) begin @(negedge clk); if (cpu_ack) acks++; end
        reset = 1'b0;
        repeat (16) begin @(negedge clk); if (cpu_ack) acks++; end
        check_val("rr_no_ack", acks, 0);
        cpu_req = 1'b1;
        for (int i = 0; i < 40 && acks == 0; i++) begin
            @(negedge clk);
            if (cpu_ack) begin acks++; cpu_req = 1'b0; end
        end
        check_val("rr_resume", acks, 1);
        check_val("rr_resume_dout", cpu_dout, 8'h5A);

        // ---- random traffic ----
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            mem_dout = 8'($urandom);
            dl_wr = 1'b0;
            if ($urandom_range(0, 11) == 0) begin
                dl_wr = 1'b1; dl_addr = 25'($urandom); dl_data = 8'($urandom);
            end
            if (cpu_ack) begin
                if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
                else new_cpu_op();
            end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                new_cpu_op(); cpu_req = 1'b1;
            end else if (cpu_req && !(m_kind == K_CPU && !m_acked) && $urandom_range(0, 40) == 0) begin
                cpu_req = 1'b0;
            end
        end
        dl_wr = 1'b0; cpu_req = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
